// File: rtl/feedback_pkg.sv
// Shared types and header layout for the multi-channel feedback C2H path.
// Holds the FSM encoding and the last-beat byte-enable helper.
package feedback_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 32;
  localparam int CH_LSB  = 32;
  localparam int CH_W    = 8;
  localparam int SEQ_LSB = 48;
  localparam int SEQ_W   = 16;

  // One bit of the last-beat tkeep: a zero remainder means a full beat.
  function automatic logic keep_bit(
    input logic [LEN_W-1:0] len,
    input int               bytes,
    input int               idx
  );
    int rem;
    rem = int'(len % 32'(bytes));
    return (rem == 0) ? 1'b1 : (idx < rem);
  endfunction

endpackage

// File: rtl/feedback_fifo.sv
// Synchronous first-word-fall-through FIFO, one per input channel.
// Writes while full are dropped; o_full is a registered flag.
module feedback_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [DW-1:0] i_din,
  input  logic          i_rd,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          r_full;
  logic          w_wr;
  logic          w_rd;
  logic [AW:0]   w_cnt_nxt;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = r_full;
  assign o_dout    = r_mem[r_rp[AW-1:0]];
  assign w_wr      = i_wr && !r_full;
  assign w_rd      = i_rd && !o_empty;
  assign w_cnt_nxt = (r_wp + (AW+1)'(w_wr)) - (r_rp + (AW+1)'(w_rd));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_full <= (w_cnt_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/feedback_c2h_mux.sv
// Multi-channel feedback C2H mux: per-channel FIFOs, round-robin grant,
// one framed packet (header + payload) per completion on AXI-Stream.
module feedback_c2h_mux
  import feedback_pkg::*;
#(
  parameter int TCQ        = 1,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                         user_clk,
  input  logic                         user_rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic [NUM_CH*32-1:0]         data_len,
  input  logic [NUM_CH-1:0]            process_done,
  output logic [NUM_CH-1:0]            fifo_full,
  output logic [DATA_WIDTH-1:0]        m_axis_c2h_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_c2h_tkeep,
  output logic                         m_axis_c2h_tlast,
  output logic                         m_axis_c2h_tvalid,
  input  logic                         m_axis_c2h_tready,
  output logic [NUM_CH-1:0]            err_overflow,
  output logic [NUM_CH-1:0]            err_overrun
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (TCQ < 0 || DATA_WIDTH % 64 != 0) begin : g_bad_width
    $error("feedback_c2h_mux: bad TCQ or DATA_WIDTH");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("feedback_c2h_mux: NUM_CH out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("feedback_c2h_mux: FIFO_DEPTH must be a power of 2");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_ch;
  logic [CW-1:0]         r_last;
  logic [31:0]           r_beats;
  logic [NUM_CH-1:0]     r_pending;
  logic [31:0]           r_len [NUM_CH];
  logic [SEQ_W-1:0]      r_seq [NUM_CH];
  logic [NUM_CH-1:0]     r_ovf;
  logic [NUM_CH-1:0]     r_ovr;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [BYTES-1:0]      r_tkeep;
  logic                  r_tlast;
  logic                  r_tvalid;

  logic [DATA_WIDTH-1:0] w_dout [NUM_CH];
  logic [NUM_CH-1:0]     w_empty;
  logic [NUM_CH-1:0]     w_pop;
  logic [CW-1:0]         w_gnt;
  logic                  w_gnt_vld;
  logic                  w_gnt_ld;
  logic                  w_out_rdy;
  logic [31:0]           w_len_g;
  logic [32:0]           w_len_rnd;
  logic [31:0]           w_beats_ld;
  logic [31:0]           w_beats_nxt;
  logic [DATA_WIDTH-1:0] w_hdr;
  logic [BYTES-1:0]      w_keep_last;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_d;
  logic [BYTES-1:0]      w_k;
  logic                  w_l;
  logic                  w_v;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    feedback_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (user_clk),
      .i_rst   (user_rst),
      .i_wr    (wr_en[c]),
      .i_din   (din[c*DATA_WIDTH +: DATA_WIDTH]),
      .i_rd    (w_pop[c]),
      .o_dout  (w_dout[c]),
      .o_empty (w_empty[c]),
      .o_full  (fifo_full[c])
    );
  end

  // Pick the pending channel closest after the last grant.
  always_comb begin : p_rr
    int best;
    int d;
    best      = NUM_CH;
    d         = 0;
    w_gnt     = r_last;
    w_gnt_vld = |r_pending;
    for (int c = 0; c < NUM_CH; c++) begin
      d = (c - int'(r_last) - 1 + 2 * NUM_CH) % NUM_CH;
      if (r_pending[c] && d < best) begin
        best  = d;
        w_gnt = CW'(c);
      end
    end
  end

  assign w_out_rdy  = !r_tvalid || m_axis_c2h_tready;
  assign w_len_g    = r_len[r_ch];
  assign w_len_rnd  = {1'b0, w_len_g} + 33'(BYTES - 1);
  assign w_beats_ld = 32'(w_len_rnd >> BSH);

  always_comb begin
    w_hdr = '0;
    w_hdr[LEN_LSB +: LEN_W] = w_len_g;
    w_hdr[CH_LSB +: CH_W]   = CH_W'(r_ch);
    w_hdr[SEQ_LSB +: SEQ_W] = r_seq[r_ch];
    for (int i = 0; i < BYTES; i++)
      w_keep_last[i] = keep_bit(w_len_g, BYTES, i);
  end

  // The output register is the beat slot; it refills whenever it drains.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_ld    = 1'b0;
    w_pop       = '0;
    w_done      = 1'b0;
    w_beats_nxt = r_beats;
    w_d         = r_tdata;
    w_k         = r_tkeep;
    w_l         = r_tlast;
    w_v         = r_tvalid && !w_out_rdy;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_gnt_ld    = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (w_out_rdy) begin
          w_v = 1'b1;
          w_d = w_hdr;
          w_k = '1;
          w_l = (w_len_g == '0);
          if (w_len_g == '0) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_beats_nxt = w_beats_ld;
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_out_rdy && !w_empty[r_ch]) begin
          w_v         = 1'b1;
          w_d         = w_dout[r_ch];
          w_pop[r_ch] = 1'b1;
          w_beats_nxt = r_beats - 32'd1;
          if (r_beats == 32'd1) begin
            w_k         = w_keep_last;
            w_l         = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_k = '1;
            w_l = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_tdata   <= '0;
      r_tkeep   <= '0;
      r_tlast   <= 1'b0;
      r_tvalid  <= 1'b0;
      r_ch      <= '0;
      r_last    <= CW'(NUM_CH - 1);
      r_beats   <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
      r_ovr     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_len[c] <= '0;
        r_seq[c] <= '0;
      end
    end else begin
      r_tdata  <= w_d;
      r_tkeep  <= w_k;
      r_tlast  <= w_l;
      r_tvalid <= w_v;
      r_beats  <= w_beats_nxt;
      if (w_gnt_ld) begin
        r_ch   <= w_gnt;
        r_last <= w_gnt;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_done && r_ch == CW'(c)) begin
          r_pending[c] <= 1'b0;
          r_seq[c]     <= r_seq[c] + 1'b1;
        end
        if (wr_en[c] && fifo_full[c]) r_ovf[c] <= 1'b1;
        if (process_done[c]) begin
          if (r_pending[c]) begin
            r_ovr[c] <= 1'b1;
          end else begin
            r_pending[c] <= 1'b1;
            r_len[c]     <= data_len[c*32 +: 32];
          end
        end
      end
    end
  end

  assign m_axis_c2h_tdata  = r_tdata;
  assign m_axis_c2h_tkeep  = r_tkeep;
  assign m_axis_c2h_tlast  = r_tlast;
  assign m_axis_c2h_tvalid = r_tvalid;
  assign err_overflow      = r_ovf;
  assign err_overrun       = r_ovr;

endmodule

// File: tb/tb_feedback_c2h_mux.sv
// Scoreboard bench for feedback_c2h_mux: stimulus queues expected beats,
// a negedge monitor pops and compares every stream handshake.
module tb_feedback_c2h_mux;

  localparam int DW    = 128;
  localparam int NCH   = 2;
  localparam int DEPTH = 64;
  localparam int BY    = DW / 8;

  logic              user_clk;
  logic              user_rst;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    wr_en;
  logic [NCH*32-1:0] data_len;
  logic [NCH-1:0]    process_done;
  logic [NCH-1:0]    fifo_full;
  logic [DW-1:0]     tdata;
  logic [BY-1:0]     tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;
  logic [NCH-1:0]    err_overflow;
  logic [NCH-1:0]    err_overrun;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [BY-1:0] k;
    logic          l;
  } beat_t;

  beat_t       exp_q[$];
  int          n_tests;
  int          n_fail;
  int          wr_idx [NCH];
  int          rd_idx [NCH];
  logic [15:0] seq_m  [NCH];
  int          tr_mode;

  feedback_c2h_mux #(
    .TCQ        (1),
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .user_clk          (user_clk),
    .user_rst          (user_rst),
    .din               (din),
    .wr_en             (wr_en),
    .data_len          (data_len),
    .process_done      (process_done),
    .fifo_full         (fifo_full),
    .m_axis_c2h_tdata  (tdata),
    .m_axis_c2h_tkeep  (tkeep),
    .m_axis_c2h_tlast  (tlast),
    .m_axis_c2h_tvalid (tvalid),
    .m_axis_c2h_tready (tready),
    .err_overflow      (err_overflow),
    .err_overrun       (err_overrun)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, required finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] word(input int c, input int i);
    return {8'hC0 + 8'(c), 24'(i), 32'(i * 7 + 3), 32'hDEAD_0000 | 32'(i), 32'(~i)};
  endfunction

  function automatic logic [DW-1:0] hdr(input int len, input int c, input logic [15:0] s);
    logic [DW-1:0] h;
    h = '0;
    h[31:0]  = 32'(len);
    h[39:32] = 8'(c);
    h[63:48] = s;
    return h;
  endfunction

  function automatic logic [BY-1:0] keepf(input int len);
    int rem;
    rem = len % 16;
    return (rem == 0) ? 16'hFFFF : 16'((32'h1 << rem) - 1);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic expect_pkt(input int c, input int len);
    beat_t b;
    int nb;
    b.d = hdr(len, c, seq_m[c]);
    b.k = '1;
    b.l = (len == 0);
    exp_q.push_back(b);
    nb = (len + 15) / 16;
    for (int i = 0; i < nb; i++) begin
      b.d = word(c, rd_idx[c]);
      rd_idx[c]++;
      b.l = (i == nb - 1);
      b.k = b.l ? keepf(len) : 16'hFFFF;
      exp_q.push_back(b);
    end
    seq_m[c]++;
  endtask

  task automatic write_words(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      din[c*DW +: DW] = word(c, wr_idx[c]);
      wr_en[c] = 1'b1;
      tick();
      wr_idx[c]++;
    end
    wr_en[c] = 1'b0;
  endtask

  task automatic write_junk(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      din[c*DW +: DW] = {DW/16{16'hBAD0 + 16'(i)}};
      wr_en[c] = 1'b1;
      tick();
    end
    wr_en[c] = 1'b0;
  endtask

  task automatic complete(input int c, input int len);
    data_len[c*32 +: 32] = 32'(len);
    process_done[c] = 1'b1;
    expect_pkt(c, len);
    tick();
    process_done[c] = 1'b0;
  endtask

  task automatic complete_pair(input int len);
    data_len = {32'(len), 32'(len)};
    process_done = 2'b11;
    expect_pkt(0, len);
    expect_pkt(1, len);
    tick();
    process_done = 2'b00;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge user_clk);
      cyc++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(posedge user_clk);
    #1;
  endtask

  initial begin : p_tready
    tready = 1'b1;
    forever begin
      @(posedge user_clk);
      #1;
      tready = (tr_mode == 2) ? 1'($urandom_range(0, 1)) : (tr_mode == 1);
    end
  end

  initial begin : p_mon
    beat_t hold;
    beat_t e;
    logic  hv;
    hv = 1'b0;
    hold = '0;
    forever begin
      @(negedge user_clk);
      if (user_rst) begin
        hv = 1'b0;
      end else begin
        if (hv) begin
          chk("hold_valid", DW'(tvalid), DW'(1));
          chk("hold_data", tdata, hold.d);
          chk("hold_keep_last", DW'({tkeep, tlast}), DW'({hold.k, hold.l}));
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h required no beat", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", tdata, e.d);
            chk("beat_keep", DW'(tkeep), DW'(e.k));
            chk("beat_last", DW'(tlast), DW'(e.l));
          end
        end
        hv = tvalid && !tready;
        hold.d = tdata;
        hold.k = tkeep;
        hold.l = tlast;
      end
    end
  end

  initial begin : p_stim
    n_tests = 0;
    n_fail = 0;
    tr_mode = 1;
    user_rst = 1'b1;
    din = '0;
    wr_en = '0;
    data_len = '0;
    process_done = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_idx[c] = 0;
      rd_idx[c] = 0;
      seq_m[c] = '0;
    end
    repeat (3) tick();
    @(negedge user_clk);
    chk("rst_tvalid", DW'(tvalid), '0);
    chk("rst_tlast", DW'(tlast), '0);
    chk("rst_tdata", tdata, '0);
    chk("rst_tkeep", DW'(tkeep), '0);
    chk("rst_fifo_full", DW'(fifo_full), '0);
    chk("rst_err", DW'({err_overflow, err_overrun}), '0);
    tick();
    user_rst = 1'b0;
    tick();

    // 100-beat packet, FIFO refilled while streaming
    write_words(0, 40);
    complete(0, 1600);
    write_words(0, 60);
    drain("long_pkt");

    // short packet with partial last beat, header latency
    write_words(0, 2);
    complete(0, 20);
    @(negedge user_clk);
    chk("lat_t0", DW'(tvalid), '0);
    @(negedge user_clk);
    chk("lat_t1", DW'(tvalid), '0);
    @(negedge user_clk);
    chk("lat_t2", DW'(tvalid), DW'(1));
    drain("short_pkt");
    write_words(0, 2);
    complete(0, 20);
    drain("short_pkt2");

    // random backpressure, then zero-length packet
    tr_mode = 2;
    write_words(1, 13);
    complete(1, 200);
    drain("rand_pkt");
    write_words(0, 5);
    complete(0, 80);
    drain("rand_pkt2");
    complete(0, 0);
    drain("zero_len");
    tr_mode = 1;

    // overflow then overrun on ch0
    write_words(0, DEPTH);
    @(negedge user_clk);
    chk("full_set", DW'(fifo_full), DW'(2'b01));
    chk("ovf_clear", DW'(err_overflow), '0);
    write_junk(0, 3);
    @(negedge user_clk);
    chk("ovf_set", DW'(err_overflow), DW'(2'b01));
    tr_mode = 0;
    tick();
    tick();
    complete(0, DEPTH * 16);
    repeat (4) tick();
    data_len[31:0] = 32'd99;
    process_done[0] = 1'b1;
    tick();
    process_done[0] = 1'b0;
    @(negedge user_clk);
    chk("ovr_set", DW'(err_overrun), DW'(2'b01));
    tr_mode = 1;
    drain("ovf_pkt");
    chk("full_clear", DW'(fifo_full), '0);

    // reset in the middle of a payload
    write_words(1, 10);
    complete(1, 160);
    repeat (6) tick();
    user_rst = 1'b1;
    exp_q.delete();
    tick();
    user_rst = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      seq_m[c] = '0;
      rd_idx[c] = wr_idx[c];
    end
    @(negedge user_clk);
    chk("mid_rst_tvalid", DW'(tvalid), '0);
    chk("mid_rst_tlast", DW'(tlast), '0);
    chk("mid_rst_flags", DW'({fifo_full, err_overflow, err_overrun}), '0);
    tick();

    // simultaneous completions, round-robin order
    write_words(0, 4);
    write_words(1, 4);
    complete_pair(64);
    drain("pair1");
    write_words(0, 4);
    write_words(1, 4);
    complete_pair(64);
    drain("pair2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
